alu: RTL and testbench
======================

# alu

Single-cycle 16-bit unsigned ALU with a registered result. It takes operands A and B and a 4-bit function code, and performs one of 15 operations: arithmetic, logic, compare or shift. The result is captured on the rising clock edge, and four combinational class flags identify the selected operation group. It is the shared datapath execution unit that sits between operand registers and the write-back path.

## Interface
- WIDTH, 16: operand and result width; every requirement below uses the default.
- CLK  in  1: rising-edge clock.
- RST  in  1: asynchronous, active-low reset; clears ALU_OUT.
- A  in  WIDTH: first operand, unsigned.
- B  in  WIDTH: second operand, unsigned.
- ALU_FUN  in  4: operation select.
- ALU_OUT  out  WIDTH: registered result.
- Arith_Flag  out  1: high when ALU_FUN is 0000..0011.
- Logic_Flag  out  1: high when ALU_FUN is 0100..1001.
- CMP_Flag  out  1: high when ALU_FUN is 1010..1100.
- Shift_Flag  out  1: high when ALU_FUN is 1101..1110.

## Operation
- Next-result decode by ALU_FUN:
  - 0000: A+B, truncated to 16 bits; carry discarded.
  - 0001: A−B, modulo 2^16; borrow discarded.
  - 0010: A*B, low 16 bits kept.
  - 0011: A/B, integer quotient. B==0 gives 0.
  - 0100: A&B.
  - 0101: A|B.
  - 0110: ~(A&B).
  - 0111: ~(A|B).
  - 1000: A^B.
  - 1001: ~(A^B).
  - 1010: 16'd1 if A==B, else 0.
  - 1011: 16'd2 if A>B, else 0.
  - 1100: 16'd3 if A<B, else 0.
  - 1101: A>>1, logical; MSB filled with 0.
  - 1110: A<<1; LSB filled with 0, MSB dropped.
  - 1111: 0.
- All comparisons are unsigned.
- Flags are pure combinational decodes of ALU_FUN only.
  - They do not depend on A, B, CLK or RST.
  - At most one flag is high at a time; all four are 0 for ALU_FUN=1111.
- No internal state other than the ALU_OUT register.

## Timing
- Reset: RST=0 asynchronously forces ALU_OUT=16'h0000, independent of CLK.
  - ALU_OUT holds 0 for as long as RST=0.
  - Flags continue to follow ALU_FUN during reset.
- RST release (0→1) is synchronous-safe. The first rising edge after release loads the decoded result.
- ALU_OUT latency: 1 cycle. A, B and ALU_FUN sampled at rising edge n appear on ALU_OUT after edge n and hold until edge n+1.
- Flag latency: 0 cycles (combinational).
  - After ALU_FUN changes mid-cycle, flags reflect the new class before ALU_OUT does.
  - The verifier checks flag/result agreement only after the edge.
- Reset asserted mid-operation: ALU_OUT clears immediately. No pending result survives reset.
- Inputs must be stable for setup/hold around the rising edge. No handshake; a new operation may be issued every cycle.

## Test plan
- Reset and arithmetic:
  - Assert RST=0 → ALU_OUT=0.
  - Release RST; A=6, B=2, FUN 0000/0001/0010/0011 on consecutive cycles → ALU_OUT 8, 4, 12, 3 one edge later; Arith_Flag=1, other flags 0.
- Logic (A=6, B=2):
  - FUN 0100..1001 → 0x0002, 0x0006, 0xFFFD, 0xFFF9, 0x0004, 0xFFFB.
  - Logic_Flag=1 throughout.
- Compare (A=6, B=2):
  - FUN 1010/1011/1100 → 0, 2, 0; CMP_Flag=1.
  - Repeat with A=B=5 → 1, 0, 0.
  - Repeat with A=1, B=9 → 0, 0, 3.
- Shift and invalid code:
  - A=6: FUN 1101 → 3; FUN 1110 → 12; Shift_Flag=1.
  - FUN 1111 → ALU_OUT=0, all flags 0.
- Boundaries:
  - A=0xFFFF, B=1: FUN 0000 → 0.
  - A=0, B=1: FUN 0001 → 0xFFFF.
  - A=0x0100, B=0x0100: FUN 0010 → 0.
  - B=0: FUN 0011 → 0.
  - A=0x8001: FUN 1110 → 0x0002.
- Async reset mid-stream:
  - Drop RST between edges while ALU_OUT=12 → ALU_OUT=0 before the next edge; flags unchanged.
  - Raise RST → next edge loads the current result.

Source files
------------

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
//
// Single-cycle unsigned ALU with a registered result. The operation selected by
// ALU_FUN is evaluated combinationally from A and B. The result is captured into
// ALU_OUT on the rising edge of CLK.
//
// Four class flags decode ALU_FUN combinationally. They depend on nothing else.
//
// Ports
//   CLK        in   1      rising-edge clock
//   RST        in   1      asynchronous active-low reset, clears ALU_OUT
//   A          in   WIDTH  first operand, unsigned
//   B          in   WIDTH  second operand, unsigned
//   ALU_FUN    in   4      operation select
//   ALU_OUT    out  WIDTH  registered result
//   Arith_Flag out  1      ALU_FUN in 0000..0011
//   Logic_Flag out  1      ALU_FUN in 0100..1001
//   CMP_Flag   out  1      ALU_FUN in 1010..1100
//   Shift_Flag out  1      ALU_FUN in 1101..1110
//
// Handshake: none. A, B and ALU_FUN are sampled on every rising edge, so a new
// operation may be issued every cycle. The result appears one edge later.
// -----------------------------------------------------------------------------
module alu #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_FUN,
    output logic [WIDTH-1:0] ALU_OUT,
    output logic             Arith_Flag,
    output logic             Logic_Flag,
    output logic             CMP_Flag,
    output logic             Shift_Flag
);

    // Operation codes
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_NAND = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_XNOR = 4'b1001;
    localparam logic [3:0] OP_CEQ  = 4'b1010;
    localparam logic [3:0] OP_CGT  = 4'b1011;
    localparam logic [3:0] OP_CLT  = 4'b1100;
    localparam logic [3:0] OP_SHR  = 4'b1101;
    localparam logic [3:0] OP_SHL  = 4'b1110;

    // Compare results are small constant codes, not booleans.
    localparam logic [WIDTH-1:0] CMP_EQ_VAL = WIDTH'(1);
    localparam logic [WIDTH-1:0] CMP_GT_VAL = WIDTH'(2);
    localparam logic [WIDTH-1:0] CMP_LT_VAL = WIDTH'(3);

    logic [WIDTH-1:0] alu_out_q;
    logic [WIDTH-1:0] alu_out_d;

    // Datapath terms. All are WIDTH wide, so carry, borrow and the high half
    // of the product fall away by truncation.
    logic [WIDTH-1:0] sum_w;
    logic [WIDTH-1:0] diff_w;
    logic [WIDTH-1:0] prod_w;
    logic [WIDTH-1:0] quot_w;
    logic             a_eq_b;
    logic             a_gt_b;
    logic             a_lt_b;

    always_comb begin
        sum_w  = A + B;
        diff_w = A - B;
        prod_w = A * B;
        // Division by zero returns 0 instead of the all-ones a bare divider gives.
        quot_w = (B == '0) ? '0 : (A / B);
        a_eq_b = (A == B);
        a_gt_b = (A > B);
        a_lt_b = (A < B);
    end

    // Next-result decode
    always_comb begin
        alu_out_d = '0;
        case (ALU_FUN)
            OP_ADD:  alu_out_d = sum_w;
            OP_SUB:  alu_out_d = diff_w;
            OP_MUL:  alu_out_d = prod_w;
            OP_DIV:  alu_out_d = quot_w;
            OP_AND:  alu_out_d = A & B;
            OP_OR:   alu_out_d = A | B;
            OP_NAND: alu_out_d = ~(A & B);
            OP_NOR:  alu_out_d = ~(A | B);
            OP_XOR:  alu_out_d = A ^ B;
            OP_XNOR: alu_out_d = ~(A ^ B);
            OP_CEQ:  alu_out_d = a_eq_b ? CMP_EQ_VAL : '0;
            OP_CGT:  alu_out_d = a_gt_b ? CMP_GT_VAL : '0;
            OP_CLT:  alu_out_d = a_lt_b ? CMP_LT_VAL : '0;
            OP_SHR:  alu_out_d = {1'b0, A[WIDTH-1:1]};
            OP_SHL:  alu_out_d = {A[WIDTH-2:0], 1'b0};
            default: alu_out_d = '0;
        endcase
    end

    // Result register: this is the only state in the block
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            alu_out_q <= '0;
        end else begin
            alu_out_q <= alu_out_d;
        end
    end

    assign ALU_OUT = alu_out_q;

    // Class flags decode ALU_FUN alone. The ranges do not overlap, and 1111
    // matches no range.
    always_comb begin
        Arith_Flag = 1'b0;
        Logic_Flag = 1'b0;
        CMP_Flag   = 1'b0;
        Shift_Flag = 1'b0;
        case (ALU_FUN)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV:                    Arith_Flag = 1'b1;
            OP_AND, OP_OR, OP_NAND, OP_NOR, OP_XOR, OP_XNOR:   Logic_Flag = 1'b1;
            OP_CEQ, OP_CGT, OP_CLT:                            CMP_Flag   = 1'b1;
            OP_SHR, OP_SHL:                                    Shift_Flag = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu.sv
module tb_alu;

    logic        CLK;
    logic        RST;
    logic [15:0] A;
    logic [15:0] B;
    logic [3:0]  ALU_FUN;
    logic [15:0] ALU_OUT;
    logic        Arith_Flag;
    logic        Logic_Flag;
    logic        CMP_Flag;
    logic        Shift_Flag;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q[$];
    int          tag_q[$];
    int          op_idx = 0;

    alu #(.WIDTH(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .A          (A),
        .B          (B),
        .ALU_FUN    (ALU_FUN),
        .ALU_OUT    (ALU_OUT),
        .Arith_Flag (Arith_Flag),
        .Logic_Flag (Logic_Flag),
        .CMP_Flag   (CMP_Flag),
        .Shift_Flag (Shift_Flag)
    );

    // Clock and reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model, written with plain integer arithmetic
    function automatic logic [15:0] model(input int a, input int b, input int fun);
        longint r;
        case (fun)
            0:  r = a + b;
            1:  r = a - b + 65536;
            2:  r = longint'(a) * longint'(b);
            3:  r = (b == 0) ? 0 : a / b;
            4:  r = a & b;
            5:  r = a | b;
            6:  r = 65535 - (a & b);
            7:  r = 65535 - (a | b);
            8:  r = a ^ b;
            9:  r = 65535 - (a ^ b);
            10: r = (a == b) ? 1 : 0;
            11: r = (a > b) ? 2 : 0;
            12: r = (a < b) ? 3 : 0;
            13: r = a / 2;
            14: r = a * 2;
            default: r = 0;
        endcase
        return 16'(r % 65536);
    endfunction

    function automatic logic [3:0] flag_model(input int fun);
        if (fun <= 3)       return 4'b1000;
        else if (fun <= 9)  return 4'b0100;
        else if (fun <= 12) return 4'b0010;
        else if (fun <= 14) return 4'b0001;
        else                return 4'b0000;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] flags_now();
        return {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag};
    endfunction

    // Driver: set the inputs at the falling edge and check the flags. At the
    // rising edge, push the expected result onto the queue.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun,
                         input logic [15:0] exp);
        @(negedge CLK);
        A = a; B = b; ALU_FUN = fun;
        #1;
        check($sformatf("flags fun=%0d", fun), {12'h0, flags_now()}, {12'h0, flag_model(int'(fun))});
        @(posedge CLK);
        exp_q.push_back(exp);
        tag_q.push_back(op_idx);
        op_idx++;
    endtask

    task automatic issue_m(input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun);
        issue(a, b, fun, model(int'(a), int'(b), int'(fun)));
    endtask

    // Monitor: each result is valid in the half-cycle after its edge
    initial begin
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                logic [15:0] e;
                int t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check($sformatf("result op#%0d", t), ALU_OUT, e);
            end
        end
    end

    initial begin
        logic [15:0] ra, rb;
        logic [3:0]  rf;
        int          drain;
        RST = 1'b0; A = 16'd0; B = 16'd0; ALU_FUN = 4'd0;
        #12;
        check("reset out", ALU_OUT, 16'h0000);
        @(posedge CLK); #1;
        check("reset hold", ALU_OUT, 16'h0000);
        @(negedge CLK);
        RST = 1'b1;

        // Arithmetic, logic, compare and shift with the test-plan operands
        issue(6, 2, 4'b0000, 16'd8);
        issue(6, 2, 4'b0001, 16'd4);
        issue(6, 2, 4'b0010, 16'd12);
        issue(6, 2, 4'b0011, 16'd3);
        issue(6, 2, 4'b0100, 16'h0002);
        issue(6, 2, 4'b0101, 16'h0006);
        issue(6, 2, 4'b0110, 16'hFFFD);
        issue(6, 2, 4'b0111, 16'hFFF9);
        issue(6, 2, 4'b1000, 16'h0004);
        issue(6, 2, 4'b1001, 16'hFFFB);
        issue(6, 2, 4'b1010, 16'd0);
        issue(6, 2, 4'b1011, 16'd2);
        issue(6, 2, 4'b1100, 16'd0);
        issue(5, 5, 4'b1010, 16'd1);
        issue(5, 5, 4'b1011, 16'd0);
        issue(5, 5, 4'b1100, 16'd0);
        issue(1, 9, 4'b1010, 16'd0);
        issue(1, 9, 4'b1011, 16'd0);
        issue(1, 9, 4'b1100, 16'd3);
        issue(6, 2, 4'b1101, 16'd3);
        issue(6, 2, 4'b1110, 16'd12);
        issue(6, 2, 4'b1111, 16'd0);

        // Boundaries
        issue(16'hFFFF, 16'd1, 4'b0000, 16'h0000);
        issue(16'h0000, 16'd1, 4'b0001, 16'hFFFF);
        issue(16'h0100, 16'h0100, 4'b0010, 16'h0000);
        issue(16'h1234, 16'h0000, 4'b0011, 16'h0000);
        issue(16'h8001, 16'h0000, 4'b1110, 16'h0002);
        issue(16'h8001, 16'h0000, 4'b1101, 16'h4000);

        // Async reset mid-stream while ALU_OUT holds 12
        issue(6, 2, 4'b0010, 16'd12);
        @(negedge CLK);          // monitor checks the 12 at this edge
        #2;
        RST = 1'b0;
        #1;
        check("async clear", ALU_OUT, 16'h0000);
        check("flags in reset", {12'h0, flags_now()}, {12'h0, flag_model(2)});
        @(posedge CLK); #1;
        check("held in reset", ALU_OUT, 16'h0000);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("after release", ALU_OUT, 16'h0000);
        issue(6, 2, 4'b0010, 16'd12);

        // Randomized operations, biased toward B==0 and A==B
        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rf = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 7))
                0: rb = 16'd0;
                1: rb = ra;
                2: begin ra = 16'($urandom_range(0, 15)); rb = 16'($urandom_range(0, 15)); end
                default: ;
            endcase
            issue_m(ra, rb, rf);
        end

        // Drain the queue, with a bounded wait
        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(posedge CLK);
            drain++;
        end
        @(posedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d results pending, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
